// File: rtl/debounce_pkg.sv
// Shared timing defaults and helpers for the multi-channel debouncer.
// Defaults are expressed in clock cycles derived from the nominal system clock.
package debounce_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    // 10 ms stable window, 500 ms first repeat, 100 ms repeat period
    localparam int unsigned DEFAULT_STABLE_CYCLES = CLK_HZ / 100;
    localparam int unsigned DEFAULT_REPEAT_DELAY  = CLK_HZ / 2;
    localparam int unsigned DEFAULT_REPEAT_PERIOD = CLK_HZ / 10;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, symmetric level filter with edge pulses,
// and an optional auto-repeat generator while the debounced level is high.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic i,
    output logic o,
    output logic rise,
    output logic fall,
    output logic rep
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   o_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   s;
    logic                   accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i};
        end
    end

    assign s      = sync_reg[SYNC_STAGES-1];
    assign accept = (s != o_reg) && (cnt_reg == CNT_LAST);

    // Any return to the current level restarts the window, so press and release filter identically.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            o_reg    <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (en) begin
                if (s == o_reg) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg  <= '0;
                    o_reg    <= s;
                    rise_reg <= s;
                    fall_reg <= ~s;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            logic [RCNT_W-1:0] rcnt_reg;
            logic              phase_reg;
            logic              rep_reg;

            // phase_reg selects the first (long) delay versus the periodic interval.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rcnt_reg  <= '0;
                    phase_reg <= 1'b0;
                    rep_reg   <= 1'b0;
                end else begin
                    rep_reg <= 1'b0;
                    if (en) begin
                        if (accept || !o_reg) begin
                            rcnt_reg  <= '0;
                            phase_reg <= 1'b0;
                        end else if (rcnt_reg == (phase_reg ? PERIOD_LAST : DELAY_LAST)) begin
                            rcnt_reg  <= '0;
                            phase_reg <= 1'b1;
                            rep_reg   <= 1'b1;
                        end else begin
                            rcnt_reg <= rcnt_reg + RCNT_W'(1);
                        end
                    end
                end
            end

            assign rep = rep_reg;
        end else begin : g_no_repeat
            assign rep = 1'b0;
        end
    endgenerate

    assign o    = o_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: independent channels sharing clock, reset and enable,
// each producing a debounced level, rise/fall pulses and optional auto-repeat pulses.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] i,
    output logic [CHANNELS-1:0] o,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rep
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            debounce_ch #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_CYCLES (STABLE_CYCLES),
                .REPEAT_EN     (REPEAT_EN),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_ch (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .i    (i[gi]),
                .o    (o[gi]),
                .rise (rise[gi]),
                .fall (fall[gi]),
                .rep  (rep[gi])
            );
        end
    endgenerate

endmodule
